// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM arbiter.
// State encodings and requester indices.
package bram_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam int REQ_CIPHER = 0;
  localparam int REQ_HOST   = 1;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    OWN0 = ST_OWN0,
    OWN1 = ST_OWN1
  } state_t;

endpackage

// File: rtl/bram_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one simple dual-port BRAM
// between a cipher core (0) and a host loader (1).
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int word_size = 32,
  parameter int addr_size = 6,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [addr_size-1:0] addr0,
  input  logic [addr_size-1:0] addr1,
  input  logic [word_size-1:0] wdata0,
  input  logic [word_size-1:0] wdata1,
  output logic [1:0]           gnt,
  output logic [1:0]           rvalid,
  output logic [word_size-1:0] rdata,
  output logic                 bram_en,
  output logic                 bram_we,
  output logic [addr_size-1:0] bram_w_addr,
  output logic [addr_size-1:0] bram_r_addr,
  output logic [word_size-1:0] bram_di,
  input  logic [word_size-1:0] bram_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  state_t        state, state_n;
  logic          last;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    rv, rv_n;
  logic          sel;
  logic          en;

  always_comb begin
    gnt = 2'b00;
    unique case (state)
      IDLE: begin
        if (&req) gnt = last ? 2'b01 : 2'b10;
        else      gnt = req;
      end
      OWN0: begin
        if (req[REQ_CIPHER] && (cnt < CMAX || !req[REQ_HOST]))
          gnt = 2'b01;
        else if (req[REQ_HOST])
          gnt = 2'b10;
      end
      OWN1: begin
        if (req[REQ_HOST] && (cnt < CMAX || !req[REQ_CIPHER]))
          gnt = 2'b10;
        else if (req[REQ_CIPHER])
          gnt = 2'b01;
      end
      default: gnt = 2'b00;
    endcase
    // Reset blocks grants even though state is already IDLE.
    if (rst) gnt = 2'b00;
  end

  assign sel = gnt[REQ_HOST];
  assign en  = |(req & gnt);

  always_comb begin
    bram_en     = en;
    bram_we     = 1'b0;
    bram_w_addr = '0;
    bram_r_addr = '0;
    bram_di     = '0;
    if (en) begin
      bram_we     = we[sel];
      bram_w_addr = sel ? addr1 : addr0;
      bram_r_addr = sel ? addr1 : addr0;
      bram_di     = sel ? wdata1 : wdata0;
    end
  end

  always_comb begin
    state_n = IDLE;
    cnt_n   = '0;
    rv_n    = 2'b00;
    if (en) begin
      state_n = sel ? OWN1 : OWN0;
      if (state_n == state)
        cnt_n = (cnt == CMAX) ? cnt : cnt + CW'(1);
      else
        cnt_n = CW'(1);
      if (!we[sel]) rv_n = sel ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      rv    <= 2'b00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rv    <= rv_n;
      if (en) last <= sel;
    end
  end

  assign rvalid = rv;
  assign rdata  = bram_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural simple dual-port BRAM.
// Inputs change on negedge; outputs sampled 1 time unit after an edge.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        bram_en, bram_we;
  logic [5:0]  bram_w_addr, bram_r_addr;
  logic [31:0] bram_di, bram_dout;

  logic [31:0] mem [64];

  int n_assert = 0;
  int n_fail   = 0;

  bram_arbiter #(
    .word_size(32),
    .addr_size(6),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .we(we),
    .addr0(addr0),
    .addr1(addr1),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .bram_en(bram_en),
    .bram_we(bram_we),
    .bram_w_addr(bram_w_addr),
    .bram_r_addr(bram_r_addr),
    .bram_di(bram_di),
    .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_w_addr] <= bram_di;
      bram_dout <= mem[bram_r_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] r, input logic [1:0] w,
                      input logic [5:0] a0, input logic [5:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    req = r; we = w;
    addr0 = a0; addr1 = a1;
    wdata0 = d0; wdata1 = d1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b11; we = 2'b00;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_en", 32'(bram_en), 32'h0);
    tick();
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // 1: write then read-after-write
    do_reset();
    beat(2'b01, 2'b01, 6'd5, 6'd0, 32'hDEADBEEF, 32'h0);
    chk("t1_wr_gnt", 32'(gnt), 32'h1);
    chk("t1_wr_we", 32'(bram_we), 32'h1);
    tick();
    chk("t1_wr_rvalid", 32'(rvalid), 32'h0);
    beat(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0);
    chk("t1_rd_gnt", 32'(gnt), 32'h1);
    chk("t1_rd_we", 32'(bram_we), 32'h0);
    tick();
    chk("t1_rvalid", 32'(rvalid), 32'h1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);

    // 2: both reading, burst of 4 then alternate
    do_reset();
    for (int i = 0; i < 12; i++) begin
      logic [1:0] e;
      e = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
      beat(2'b11, 2'b00, 6'd5, 6'd5, 32'h0, 32'h0);
      chk($sformatf("t2_gnt_%0d", i), 32'(gnt), 32'(e));
      tick();
      chk($sformatf("t2_rvalid_%0d", i), 32'(rvalid), 32'(e));
      chk($sformatf("t2_rdata_%0d", i), rdata, 32'hDEADBEEF);
    end
    beat(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    tick();
    chk("t2_drain", 32'(rvalid), 32'h0);

    // 3: tie-break follows last owner
    do_reset();
    beat(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0);
    chk("t3_first_tie", 32'(gnt), 32'h1);
    tick();
    beat(2'b00, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0);
    chk("t3_idle", 32'(gnt), 32'h0);
    tick();
    beat(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0);
    chk("t3_second_tie", 32'(gnt), 32'h2);
    tick();
    beat(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    tick();

    // 4: lone requester holds past burst limit
    do_reset();
    for (int i = 0; i < 10; i++) begin
      beat(2'b01, 2'b00, 6'd5, 6'd5, 32'h0, 32'h0);
      chk($sformatf("t4_hold_%0d", i), 32'(gnt), 32'h1);
      tick();
    end
    beat(2'b11, 2'b00, 6'd5, 6'd5, 32'h0, 32'h0);
    chk("t4_switch", 32'(gnt), 32'h2);
    tick();
    chk("t4_rvalid", 32'(rvalid), 32'h2);
    beat(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    tick();

    // 5: writes only
    do_reset();
    for (int i = 0; i < 8; i++) begin
      beat(2'b11, 2'b11, 6'd20, 6'd21,
           32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i));
      chk($sformatf("t5_gnt_%0d", i), 32'(gnt),
          (i < 4) ? 32'h1 : 32'h2);
      tick();
      chk($sformatf("t5_rvalid_%0d", i), 32'(rvalid), 32'h0);
    end
    beat(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    tick();
    chk("t5_mem20", mem[20], 32'hA0000003);
    chk("t5_mem21", mem[21], 32'hB0000007);
    beat(2'b01, 2'b00, 6'd20, 6'd0, 32'h0, 32'h0);
    tick();
    chk("t5_rd20_rvalid", 32'(rvalid), 32'h1);
    chk("t5_rd20", rdata, 32'hA0000003);
    beat(2'b10, 2'b00, 6'd0, 6'd21, 32'h0, 32'h0);
    chk("t5_rd21_gnt", 32'(gnt), 32'h2);
    tick();
    chk("t5_rd21_rvalid", 32'(rvalid), 32'h2);
    chk("t5_rd21", rdata, 32'hB0000007);

    // 6: async reset mid-cycle
    do_reset();
    beat(2'b10, 2'b00, 6'd5, 6'd5, 32'h0, 32'h0);
    chk("t6_pre_gnt", 32'(gnt), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    chk("t6_rst_en", 32'(bram_en), 32'h0);
    chk("t6_rst_we", 32'(bram_we), 32'h0);
    tick();
    chk("t6_rst_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    #1;
    chk("t6_first_gnt", 32'(gnt), 32'h1);
    tick();
    chk("t6_rvalid", 32'(rvalid), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("t6_inflight_drop", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 2'b00;
    tick();
    chk("t6_post_rvalid", 32'(rvalid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
